// File: rtl/comp_seq_ctrl_if.sv
// Request/response bus for comp_seq_ctrl.
// master drives the request operands and rsp_ready_i.
// slave (the comparator) drives req_ready_o, the response flags and busy_o.
// Signal suffixes are named from the comparator's point of view.
interface comp_seq_ctrl_if;
    localparam int unsigned DW = 32;

    logic          req_valid_i;
    logic          req_ready_o;
    logic [DW-1:0] a_i;
    logic [DW-1:0] b_i;
    logic          signed_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic          bg_o;
    logic          sl_o;
    logic          eq_o;
    logic          busy_o;

    modport master (
        output req_valid_i, a_i, b_i, signed_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, bg_o, sl_o, eq_o, busy_o
    );

    modport slave (
        input  req_valid_i, a_i, b_i, signed_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, bg_o, sl_o, eq_o, busy_o
    );
endinterface

// File: rtl/comp_seq_ctrl.sv
// Sequential 32-bit magnitude comparator.
// The operands are scanned one nibble per cycle, most significant nibble first.
// Signed compares flip both sign bits, so that the unsigned scan yields two's-complement order.
// Ports:
//   clk_i  - clock, rising edge.
//   rst_ni - asynchronous active-low reset.
//   bus    - slave side of comp_seq_ctrl_if:
//            request (valid/ready, a, b, signed), response (valid/ready, bg/sl/eq), busy.
// Parameter:
//   EARLY_EXIT - 1: stop at the first unequal nibble. 0: always scan all 8 nibbles.
module comp_seq_ctrl #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    comp_seq_ctrl_if.slave bus
);
    localparam int unsigned DW   = 32;
    localparam int unsigned NW   = 4;
    localparam int unsigned IW   = 3;
    localparam int unsigned NNIB = DW / NW;

    localparam logic [IW-1:0] TOP_IDX = IW'(NNIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          dec_q, dec_d;        // a nibble already differed (full-scan mode)
    logic          dec_bg_q, dec_bg_d;  // direction of that first difference
    logic          bg_q, bg_d;
    logic          sl_q, sl_d;
    logic          eq_q, eq_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;

    logic [NW-1:0] nib_a_c;
    logic [NW-1:0] nib_b_c;
    logic          nib_bg_c;
    logic          nib_sl_c;
    logic          nib_eq_c;
    logic          last_c;

    // 4-bit magnitude compare; the result is {bg, sl, eq}.
    function automatic logic [2:0] nib_cmp(input logic [NW-1:0] x, input logic [NW-1:0] y);
        logic [NW-1:0] xn;
        logic          gt;
        logic          eq;
        xn = ~(x ^ y);
        gt = (x[3] & ~y[3])
           | (xn[3] & x[2] & ~y[2])
           | (xn[3] & xn[2] & x[1] & ~y[1])
           | (xn[3] & xn[2] & xn[1] & x[0] & ~y[0]);
        eq = &xn;
        return {gt, ~gt & ~eq, eq};
    endfunction

    // Current nibble pair, selected by the scan index.
    always_comb begin
        nib_a_c = NW'(a_q >> {idx_q, 2'b00});
        nib_b_c = NW'(b_q >> {idx_q, 2'b00});
        {nib_bg_c, nib_sl_c, nib_eq_c} = nib_cmp(nib_a_c, nib_b_c);
        last_c = (idx_q == '0) || (EARLY_EXIT && !nib_eq_c);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            dec_q    <= 1'b0;
            dec_bg_q <= 1'b0;
            bg_q     <= 1'b0;
            sl_q     <= 1'b0;
            eq_q     <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            dec_q    <= dec_d;
            dec_bg_q <= dec_bg_d;
            bg_q     <= bg_d;
            sl_q     <= sl_d;
            eq_q     <= eq_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state, datapath and status logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        dec_d    = dec_q;
        dec_bg_d = dec_bg_q;
        bg_d     = bg_q;
        sl_d     = sl_q;
        eq_d     = eq_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    a_d      = {bus.a_i[DW-1] ^ bus.signed_i, bus.a_i[DW-2:0]};
                    b_d      = {bus.b_i[DW-1] ^ bus.signed_i, bus.b_i[DW-2:0]};
                    idx_d    = TOP_IDX;
                    dec_d    = 1'b0;
                    dec_bg_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Only the first difference counts; later nibbles cannot overturn it.
                if (!dec_q && !nib_eq_c) begin
                    dec_d    = 1'b1;
                    dec_bg_d = nib_bg_c;
                end
                if (last_c) begin
                    state_d = DONE;
                    if (dec_q) begin
                        bg_d = dec_bg_q;
                        sl_d = !dec_bg_q;
                        eq_d = 1'b0;
                    end else begin
                        bg_d = nib_bg_c;
                        sl_d = nib_sl_c;
                        eq_d = nib_eq_c;
                    end
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered and track the next state.
    always_comb begin
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == RUN);
        valid_d = (state_d == DONE);
    end

    assign bus.req_ready_o = ready_q;
    assign bus.busy_o      = busy_q;
    assign bus.rsp_valid_o = valid_q;
    assign bus.bg_o        = bg_q;
    assign bus.sl_o        = sl_q;
    assign bus.eq_o        = eq_q;
endmodule

// File: tb/tb_comp_seq_ctrl.sv
module tb_comp_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    comp_seq_ctrl_if ife ();
    comp_seq_ctrl_if ifn ();

    comp_seq_ctrl #(.EARLY_EXIT(1'b1)) dut_e (.clk_i(clk), .rst_ni(rst_n), .bus(ife));
    comp_seq_ctrl #(.EARLY_EXIT(1'b0)) dut_n (.clk_i(clk), .rst_ni(rst_n), .bus(ifn));

    typedef struct {
        logic bg;
        logic sl;
        logic eq;
        int   lat;
    } exp_t;

    exp_t qe[$];
    exp_t qn[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   acc_cyc [2];
    int   busy_cnt[2];
    logic prev_rv [2];
    logic prev_rr [2];
    logic prev_hs [2];
    logic [2:0] prev_fl[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int side, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, side, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned compare; the latency is the position of the first differing nibble.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s, input bit ee);
        exp_t e;
        logic [31:0] x;
        bit found;
        if (s) begin
            e.bg = $signed(a) > $signed(b);
            e.sl = $signed(a) < $signed(b);
        end else begin
            e.bg = a > b;
            e.sl = a < b;
        end
        e.eq = (a == b);
        e.lat = 8;
        found = 0;
        x = a ^ b;
        if (ee) begin
            for (int k = 7; k >= 0; k--) begin
                if (!found && ((x >> (4 * k)) & 32'hF) != 0) begin
                    found = 1;
                    e.lat = 8 - k;
                end
            end
        end
        return e;
    endfunction

    task automatic mon(input int side, input logic rv, input logic rq, input logic vreq,
                       input logic busy, input logic rr, input logic [2:0] fl);
        exp_t e;
        bit   empty;
        if (prev_hs[side]) begin
            chk("post_hs_valid", side, 64'(rv), 64'd0);
            chk("post_hs_ready", side, 64'(rq), 64'd1);
            chk("keep_flags", side, 64'(fl), 64'(prev_fl[side]));
        end
        if (vreq && rq) begin
            acc_cyc[side]  = cyc + 1;
            busy_cnt[side] = 0;
        end
        if (busy) busy_cnt[side]++;
        if (rv) chk("onehot", side, 64'($countones(fl)), 64'd1);
        if (rv && !prev_rv[side]) begin
            empty = (side == 0) ? (qe.size() == 0) : (qn.size() == 0);
            if (empty) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp dut%0d: got rsp_valid 1 expected 0", side);
            end else begin
                if (side == 0) e = qe.pop_front();
                else           e = qn.pop_front();
                chk("flags", side, 64'(fl), 64'({e.bg, e.sl, e.eq}));
                chk("latency", side, 64'(cyc - acc_cyc[side]), 64'(e.lat));
                chk("busy_cycles", side, 64'(busy_cnt[side]), 64'(e.lat));
            end
        end else if (rv && !prev_rr[side]) begin
            chk("hold_flags", side, 64'(fl), 64'(prev_fl[side]));
            chk("hold_ready", side, 64'(rq), 64'd0);
        end
        prev_hs[side] = rv && rr;
        prev_rv[side] = rv;
        prev_rr[side] = rr;
        prev_fl[side] = fl;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                prev_hs[i] = 1'b0;
                prev_rv[i] = 1'b0;
                prev_rr[i] = 1'b0;
                prev_fl[i] = 3'b000;
            end
        end else begin
            mon(0, ife.rsp_valid_o, ife.req_ready_o, ife.req_valid_i, ife.busy_o, ife.rsp_ready_i,
                {ife.bg_o, ife.sl_o, ife.eq_o});
            mon(1, ifn.rsp_valid_o, ifn.req_ready_o, ifn.req_valid_i, ifn.busy_o, ifn.rsp_ready_i,
                {ifn.bg_o, ifn.sl_o, ifn.eq_o});
        end
    end

    task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        ife.req_valid_i = v; ife.a_i = a; ife.b_i = b; ife.signed_i = s;
        ifn.req_valid_i = v; ifn.a_i = a; ifn.b_i = b; ifn.signed_i = s;
    endtask

    task automatic set_rr(input logic r);
        ife.rsp_ready_i = r;
        ifn.rsp_ready_i = r;
    endtask

    task automatic set_junk_valid();
        logic v;
        v = 1'($urandom_range(0, 1));
        ife.req_valid_i = v;
        ifn.req_valid_i = v;
    endtask

    task automatic check_idle_reset(input string name);
        chk({name, "_ready"}, 0, 64'(ife.req_ready_o), 64'd1);
        chk({name, "_ready"}, 1, 64'(ifn.req_ready_o), 64'd1);
        chk({name, "_out"}, 0, 64'({ife.rsp_valid_o, ife.busy_o, ife.bg_o, ife.sl_o, ife.eq_o}), 64'd0);
        chk({name, "_out"}, 1, 64'({ifn.rsp_valid_o, ifn.busy_o, ifn.bg_o, ifn.sl_o, ifn.eq_o}), 64'd0);
    endtask

    // Called at posedge+1; the request is accepted on the following edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n = 0;
        while (!(ife.req_ready_o && ifn.req_ready_o)) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout: got req_ready 0 expected 1");
                return;
            end
        end
        qe.push_back(model(a, b, s, 1'b1));
        qn.push_back(model(a, b, s, 1'b0));
        drive_req(1'b1, a, b, s);
        @(posedge clk); #1;
        drive_req(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic finish_op(input int hold);
        int n = 0;
        while (!(ife.rsp_valid_o && ifn.rsp_valid_o)) begin
            set_junk_valid();
            @(posedge clk); #1;
            n++;
            if (n > 30) begin
                checks++; errors++;
                $display("FAIL rsp_timeout: got rsp_valid %0b/%0b expected 1/1", ife.rsp_valid_o, ifn.rsp_valid_o);
                break;
            end
        end
        repeat (hold) begin
            set_junk_valid();
            @(posedge clk); #1;
        end
        ife.req_valid_i = 1'b0;
        ifn.req_valid_i = 1'b0;
        set_rr(1'b1);
        @(posedge clk); #1;
        set_rr(1'b0);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
        issue(a, b, s);
        finish_op(hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, m;
        int k;
        drive_req(1'b0, 32'd0, 32'd0, 1'b0);
        set_rr(1'b0);
        rst_n = 1'b0;
        #12;
        check_idle_reset("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1);
        op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        op(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        op(32'h1234_5678, 32'h1234_5679, 1'b0, 2);
        op(32'h1234_5678, 32'h1234_5678, 1'b1, 5);
        op(32'hF000_0000, 32'h0000_0000, 1'b0, 0);
        op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);

        // Reset in the third cycle of a full scan discards the operation.
        drive_req(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0);
        @(posedge clk); #1;
        drive_req(1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_reset("mid_run_reset");
        qe.delete();
        qn.delete();
        @(posedge clk); #1;
        qe.push_back(model(32'd5, 32'd3, 1'b0, 1'b1));
        qn.push_back(model(32'd5, 32'd3, 1'b0, 1'b0));
        drive_req(1'b1, 32'd5, 32'd3, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("accept_after_reset", 0, 64'(ife.busy_o), 64'd1);
        chk("accept_after_reset", 1, 64'(ifn.busy_o), 64'd1);
        drive_req(1'b0, $urandom, $urandom, 1'b1);
        finish_op(0);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: begin
                    k = $urandom_range(0, 7);
                    m = (32'h1 << (4 * k)) - 32'h1;
                    b = a ^ ($urandom & m);
                end
            endcase
            op(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 0, 64'(qe.size()), 64'd0);
        chk("queue_empty", 1, 64'(qn.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
